// File: rtl/vga_sync_if.sv
// Timing-capture bus between the VGA sync source and the receive-side decoder.
interface vga_sync_if;
  logic        clk_en;
  logic        hsync_in;
  logic        vsync_in;
  logic [10:0] x_pos;
  logic [9:0]  y_pos;
  logic        de;
  logic        frame_start;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;
  logic        locked;
  logic        sync_err;

  modport master (
    output clk_en, hsync_in, vsync_in,
    input  x_pos, y_pos, de, frame_start, line_len, frame_lines, locked, sync_err
  );

  modport slave (
    input  clk_en, hsync_in, vsync_in,
    output x_pos, y_pos, de, frame_start, line_len, frame_lines, locked, sync_err
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates and data enable from
// active-low hsync/vsync, measures line and frame length, and tracks lock.
module vga_sync_decoder #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned H_TOTAL    = 800,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned V_TOTAL    = 525,
  parameter int unsigned H_TOL      = 1,
  parameter int unsigned V_TOL      = 1,
  parameter int unsigned LOCK_LINES = 8
) (
  input  logic      clk,
  input  logic      reset_n,
  vga_sync_if.slave bus
);

  localparam int unsigned HW = 11;
  localparam int unsigned VW = 10;
  localparam int unsigned GW = $clog2(LOCK_LINES + 1);

  localparam logic [HW-1:0] H_START   = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_END     = HW'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [HW-1:0] H_LO      = HW'(H_TOTAL - H_TOL);
  localparam logic [HW-1:0] H_HI      = HW'(H_TOTAL + H_TOL);
  localparam logic [HW-1:0] H_SAT     = '1;
  localparam logic [VW-1:0] V_START   = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_END     = VW'(V_SYNC + V_BACK + V_VISIBLE);
  localparam logic [VW-1:0] V_LO      = VW'(V_TOTAL - V_TOL);
  localparam logic [VW-1:0] V_HI      = VW'(V_TOTAL + V_TOL);
  localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_LINES - 1);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic          h_arm_q, h_arm_d, v_arm_q, v_arm_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [GW-1:0] good_q, good_d;
  logic          seen_q, seen_d;
  logic [HW-1:0] line_len_q, line_len_d;
  logic [VW-1:0] frame_lines_q, frame_lines_d;
  logic [HW-1:0] x_q, x_d;
  logic [VW-1:0] y_q, y_d;
  logic          de_q, de_d;
  logic          fs_q, fs_d;
  logic          err_q, err_d;
  logic          locked_q, locked_d;

  logic h_edge, v_edge, line_ok, frame_ok, in_h, in_v, sat;

  // Falling edges count only after a genuine high sample has been seen since reset.
  assign h_edge   = h_arm_q & hs_q & ~bus.hsync_in;
  assign v_edge   = v_arm_q & vs_q & ~bus.vsync_in;
  assign line_ok  = (hcnt_q >= H_LO) && (hcnt_q <= H_HI);
  assign frame_ok = (vcnt_q >= V_LO) && (vcnt_q <= V_HI);
  assign in_h     = (hcnt_q >= H_START) && (hcnt_q < H_END);
  assign in_v     = (vcnt_q >= V_START) && (vcnt_q < V_END);
  assign sat      = (hcnt_q == H_SAT);

  // Next-state: counters, measurements, lock FSM and registered outputs.
  always_comb begin
    state_d       = state_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    h_arm_d       = h_arm_q;
    v_arm_d       = v_arm_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    good_d        = good_q;
    seen_d        = seen_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    x_d           = x_q;
    y_d           = y_q;
    de_d          = de_q;
    locked_d      = locked_q;
    fs_d          = 1'b0;
    err_d         = 1'b0;

    if (bus.clk_en) begin
      hs_d    = bus.hsync_in;
      vs_d    = bus.vsync_in;
      h_arm_d = h_arm_q | bus.hsync_in;
      v_arm_d = v_arm_q | bus.vsync_in;

      if (h_edge) begin
        hcnt_d     = HW'(1);
        line_len_d = hcnt_q;
      end else if (!sat) begin
        hcnt_d = hcnt_q + HW'(1);
      end

      if (v_edge) begin
        vcnt_d        = '0;
        frame_lines_d = vcnt_q;
      end else if (h_edge) begin
        vcnt_d = vcnt_q + VW'(1);
      end

      fs_d = v_edge;

      // Window decode uses the pre-update counters, giving one tick of lag.
      if (in_h && in_v && locked_q) begin
        x_d  = hcnt_q - H_START;
        y_d  = vcnt_q - V_START;
        de_d = 1'b1;
      end else begin
        x_d  = '0;
        y_d  = '0;
        de_d = 1'b0;
      end

      case (state_q)
        S_SEARCH: begin
          if (h_edge) begin
            state_d = S_VERIFY;
            good_d  = '0;
          end
        end
        S_VERIFY: begin
          if (h_edge && line_ok) begin
            good_d = good_q + GW'(1);
            if (good_q == LOCK_LAST) state_d = S_LOCKED;
          end else if (h_edge || sat) begin
            state_d = S_SEARCH;
            err_d   = 1'b1;
          end
        end
        S_LOCKED: begin
          if ((h_edge && !line_ok) || (v_edge && seen_q && !frame_ok) || (sat && !h_edge)) begin
            state_d = S_SEARCH;
            err_d   = 1'b1;
          end else if (v_edge) begin
            seen_d = 1'b1;
          end
        end
        default: state_d = S_SEARCH;
      endcase

      if (state_d != S_LOCKED) seen_d = 1'b0;
      locked_d = (state_d == S_LOCKED);
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q       <= S_SEARCH;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      h_arm_q       <= 1'b0;
      v_arm_q       <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      good_q        <= '0;
      seen_q        <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      x_q           <= '0;
      y_q           <= '0;
      de_q          <= 1'b0;
      fs_q          <= 1'b0;
      err_q         <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      h_arm_q       <= h_arm_d;
      v_arm_q       <= v_arm_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      good_q        <= good_d;
      seen_q        <= seen_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      fs_q          <= fs_d;
      err_q         <= err_d;
      locked_q      <= locked_d;
    end
  end

  assign bus.x_pos       = x_q;
  assign bus.y_pos       = y_q;
  assign bus.de          = de_q;
  assign bus.frame_start = fs_q;
  assign bus.line_len    = line_len_q;
  assign bus.frame_lines = frame_lines_q;
  assign bus.locked      = locked_q;
  assign bus.sync_err    = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a scaled-timing instance for lock/length/error corner
// cases and a default 640x480 instance for lock timing and the visible window.
module tb_vga_sync_decoder;

  // Scaled timing: 16 visible + 5 front + 4 sync + 3 back = 28; 6 + 2 + 2 + 3 = 13 lines.
  localparam int HV = 16, HS = 4, HB = 3, HT = 28;
  localparam int VV = 6,  VS = 2, VB = 3, VT = 13;
  localparam int HS0 = HT - HS - HB;
  localparam int VS0 = VT - VS - VB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_std;
  vga_sync_if bus();
  vga_sync_if bus_std();

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
    .H_TOL(1), .V_TOL(1), .LOCK_LINES(8)
  ) dut (
    .clk(clk), .reset_n(rst), .bus(bus)
  );

  vga_sync_decoder dut_std (
    .clk(clk), .reset_n(rst_std), .bus(bus_std)
  );

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse counters and pulse-width watch on the scaled instance.
  int   err_cnt = 0, fs_cnt = 0, wide_cnt = 0;
  logic err_prev = 1'b0, fs_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.sync_err)    err_cnt <= err_cnt + 1;
    if (bus.frame_start) fs_cnt  <= fs_cnt + 1;
    if ((bus.sync_err && err_prev) || (bus.frame_start && fs_prev)) wide_cnt <= wide_cnt + 1;
    err_prev <= bus.sync_err;
    fs_prev  <= bus.frame_start;
  end

  logic        chk = 1'b0, exp_lock = 1'b0;
  int          pix_err = 0, de_cnt = 0, vc_g = 0;
  logic [10:0] last_x = '0;
  logic [9:0]  last_y = '0;
  logic        last_de = 1'b0;

  typedef struct {
    int   len;
    logic lock;
    int   llen;
    int   err;
    int   fl;
  } vec_t;
  vec_t vec [23];

  // One pixel tick, preceded by div-1 idle clocks; outputs must hold while idle.
  task automatic tx_tick(input logic hs, input logic vs, input int div);
    for (int k = 0; k < div - 1; k++) begin
      bus.clk_en = 1'b0; bus.hsync_in = hs; bus.vsync_in = vs;
      @(posedge clk); #1;
      if (chk && (bus.x_pos !== last_x || bus.y_pos !== last_y || bus.de !== last_de)) pix_err++;
    end
    bus.clk_en = 1'b1; bus.hsync_in = hs; bus.vsync_in = vs;
    @(posedge clk); #1;
    last_x = bus.x_pos; last_y = bus.y_pos; last_de = bus.de;
  endtask

  task automatic tx_line(input int len, input int vc, input int div);
    int ex, ey;
    logic ede;
    for (int hc = 0; hc < len; hc++) begin
      tx_tick(!(hc >= HS0 && hc < HS0 + HS), !(vc >= VS0 && vc < VS0 + VS), div);
      if (chk) begin
        ede = exp_lock && hc < HV && vc < VV;
        ex  = ede ? hc : 0;
        ey  = ede ? vc : 0;
        if (bus.de) de_cnt++;
        if (bus.de !== ede || bus.x_pos !== 11'(ex) || bus.y_pos !== 10'(ey)) pix_err++;
      end
    end
  endtask

  task automatic next_lines(input int n, input int div);
    for (int i = 0; i < n; i++) begin
      tx_line(HT, vc_g, div);
      vc_g = (vc_g + 1) % VT;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_x"},      int'(bus.x_pos), 0);
    check({tag, "_y"},      int'(bus.y_pos), 0);
    check({tag, "_de"},     int'(bus.de), 0);
    check({tag, "_fs"},     int'(bus.frame_start), 0);
    check({tag, "_len"},    int'(bus.line_len), 0);
    check({tag, "_flines"}, int'(bus.frame_lines), 0);
    check({tag, "_locked"}, int'(bus.locked), 0);
    check({tag, "_err"},    int'(bus.sync_err), 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; bus.clk_en = 1'b1; bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs(tag);
    rst = 1'b0;
    vc_g = 0; last_x = '0; last_y = '0; last_de = 1'b0;
  endtask

  task automatic pixel_frame(input string tag, input int div);
    int fs0;
    chk = 1'b1; pix_err = 0; de_cnt = 0; fs0 = fs_cnt;
    next_lines(VT, div);
    chk = 1'b0;
    check({tag, "_pix"},    pix_err, 0);
    check({tag, "_de_cnt"}, de_cnt, HV * VV);
    check({tag, "_fs_cnt"}, fs_cnt - fs0, 1);
    check({tag, "_locked"}, int'(bus.locked), 1);
    check({tag, "_flines"}, int'(bus.frame_lines), VT);
    check({tag, "_len"},    int'(bus.line_len), HT);
  endtask

  task automatic main_seq();
    int e0;
    vec[0] = '{28, 1'b0, 21, 0, 0};
    for (int i = 1; i < 8; i++) vec[i] = '{28, 1'b0, 28, 0, 0};
    vec[8]  = '{28, 1'b1, 28, 0, 8};
    vec[9]  = '{29, 1'b1, 28, 0, 8};
    vec[10] = '{27, 1'b1, 29, 0, 8};
    vec[11] = '{28, 1'b1, 27, 0, 8};
    vec[12] = '{38, 1'b1, 28, 0, 8};
    vec[13] = '{28, 1'b0, 38, 1, 8};
    for (int i = 14; i < 21; i++) vec[i] = '{28, 1'b0, 28, 0, 8};
    vec[21] = '{28, 1'b0, 28, 0, 13};
    vec[22] = '{28, 1'b1, 28, 0, 13};

    do_reset("rst");

    // Lock acquisition, tolerated lengths, an out-of-range line, and relock.
    for (int i = 0; i < 23; i++) begin
      e0 = err_cnt;
      tx_line(vec[i].len, vc_g, 1);
      vc_g = (vc_g + 1) % VT;
      check($sformatf("vec%0d_locked", i), int'(bus.locked), int'(vec[i].lock));
      check($sformatf("vec%0d_len", i),    int'(bus.line_len), vec[i].len == 0 ? 0 : vec[i].llen);
      check($sformatf("vec%0d_err", i),    err_cnt - e0, vec[i].err);
      check($sformatf("vec%0d_flines", i), int'(bus.frame_lines), vec[i].fl);
    end

    // Full locked frame: coordinates and data enable over the visible window.
    exp_lock = 1'b1;
    next_lines(VT - vc_g, 1);
    pixel_frame("frame1", 1);

    // A 15-line frame while locked trips the frame-length check at the next vsync.
    e0 = err_cnt;
    for (int vc = 0; vc < 15; vc++) tx_line(HT, vc, 1);
    for (int vc = 0; vc <= VS0; vc++) tx_line(HT, vc, 1);
    vc_g = VS0 + 1;
    check("frame_err_cnt",    err_cnt - e0, 1);
    check("frame_err_locked", int'(bus.locked), 0);
    check("frame_err_flines", int'(bus.frame_lines), 15);
    check("frame_err_de",     int'(bus.de), 0);
    e0 = err_cnt;
    next_lines(7, 1);
    check("relock7_locked", int'(bus.locked), 0);
    next_lines(1, 1);
    check("relock8_locked", int'(bus.locked), 1);
    check("relock_err",     err_cnt - e0, 0);

    // hsync stuck high: one timeout error once hcnt saturates, never repeated.
    e0 = err_cnt;
    repeat (2000) tx_tick(1'b1, 1'b1, 1);
    check("sat_early_err",    err_cnt - e0, 0);
    check("sat_early_locked", int'(bus.locked), 1);
    repeat (100) tx_tick(1'b1, 1'b1, 1);
    check("sat_err",    err_cnt - e0, 1);
    check("sat_locked", int'(bus.locked), 0);
    check("sat_de",     int'(bus.de), 0);
    check("sat_len",    int'(bus.line_len), HT);

    // Reset mid-line with hsync held low; the held-low level must not be taken as an edge.
    for (int hc = 0; hc <= HS0 + 1; hc++) tx_tick(!(hc >= HS0), 1'b1, 1);
    check("pre_rst_len_nonzero", int'(bus.line_len != 11'd0), 1);
    rst = 1'b1; bus.hsync_in = 1'b0;
    @(posedge clk); #1;
    check_zero_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    e0 = err_cnt;
    for (int hc = HS0 + 2; hc < HT; hc++) tx_tick(!(hc < HS0 + HS), 1'b1, 1);
    tx_line(HT, 1, 1);
    check("midrst_first_len", int'(bus.line_len), 26);
    check("midrst_locked0",   int'(bus.locked), 0);
    for (int vc = 2; vc <= 8; vc++) tx_line(HT, vc, 1);
    check("midrst_locked8",   int'(bus.locked), 0);
    tx_line(HT, 9, 1);
    check("midrst_locked9",   int'(bus.locked), 1);
    check("midrst_err",       err_cnt - e0, 0);

    // Quarter-rate pixel enable must reproduce the full-rate behaviour.
    exp_lock = 1'b0;
    do_reset("rst4");
    e0 = err_cnt;
    next_lines(8, 4);
    check("q4_locked8", int'(bus.locked), 0);
    next_lines(1, 4);
    check("q4_locked9", int'(bus.locked), 1);
    exp_lock = 1'b1;
    next_lines(VT - vc_g, 4);
    pixel_frame("q4_frame", 4);
    check("q4_err", err_cnt - e0, 0);
    check("pulse_width", wide_cnt, 0);
  endtask

  // Default 640x480 instance: lock on the 9th edge, line length, one visible line.
  task automatic std_seq();
    int   pix_bad = 0, de_n = 0;
    logic ede;
    rst_std = 1'b1; bus_std.clk_en = 1'b1; bus_std.hsync_in = 1'b1; bus_std.vsync_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_std = 1'b0;
    for (int l = 0; l < 40; l++) begin
      for (int hc = 0; hc < 800; hc++) begin
        bus_std.hsync_in = !(hc >= 656 && hc < 752);
        @(posedge clk); #1;
        if (l == 38) begin
          ede = hc < 640;
          if (bus_std.de) de_n++;
          if (bus_std.de !== ede || bus_std.x_pos !== (ede ? 11'(hc) : 11'd0) ||
              bus_std.y_pos !== (ede ? 10'd3 : 10'd0)) pix_bad++;
        end
      end
      check($sformatf("std_l%0d_locked", l), int'(bus_std.locked), (l >= 8) ? 1 : 0);
      check($sformatf("std_l%0d_len", l),    int'(bus_std.line_len), (l == 0) ? 656 : 800);
    end
    check("std_pix",    pix_bad, 0);
    check("std_de_cnt", de_n, 640);
    check("std_err",    int'(bus_std.sync_err), 0);
  endtask

  initial begin
    fork
      main_seq();
      std_seq();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
